// File: rtl/sw_alloc_sched_pkg.sv
// Shared constants and types for the bless_mc switch-allocator scheduler.
package sw_alloc_sched_pkg;

    localparam int NUM_CH         = 4;
    localparam int NUM_PORT       = 4;
    localparam int PC_INDEX_WIDTH = 3;
    localparam int RANK_W         = 2;

    typedef logic [NUM_PORT-1:0] pv_t;
    typedef logic [RANK_W-1:0]   rank_t;

    function automatic logic [PC_INDEX_WIDTH-1:0] popCount4(input logic [NUM_CH-1:0] v);
        logic [PC_INDEX_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) n = n + PC_INDEX_WIDTH'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/sw_alloc_sched_if.sv
// Channel handshake, allocator and output bundle of the scheduler.
interface sw_alloc_sched_if
    import sw_alloc_sched_pkg::*;
#(
    parameter int AGE_W = 8
);
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH-1:0]            in_mc;
    logic [NUM_CH*NUM_PORT-1:0]   in_ppv;
    logic [NUM_CH*AGE_W-1:0]      in_age;
    logic [NUM_CH-1:0]            al_mc;
    logic [NUM_CH*NUM_PORT-1:0]   al_ppv;
    logic [PC_INDEX_WIDTH-1:0]    al_numflit;
    logic [NUM_CH*NUM_PORT-1:0]   al_pv;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH*NUM_PORT-1:0]   out_pv;
    logic [NUM_CH-1:0]            out_last;
    logic [NUM_CH-1:0]            starve;

    modport slave (
        input  in_valid, in_mc, in_ppv, in_age, al_pv,
        output in_ready, al_mc, al_ppv, al_numflit, out_valid, out_pv, out_last, starve
    );

    modport master (
        output in_valid, in_mc, in_ppv, in_age, al_pv,
        input  in_ready, al_mc, al_ppv, al_numflit, out_valid, out_pv, out_last, starve
    );
endinterface

// File: rtl/sw_alloc_sched_rank4.sv
// Combinational 4-key rank network: higher key ranks earlier, ties to the lower index.
module sched_rank4
    import sw_alloc_sched_pkg::*;
#(
    parameter int KEY_W = 10
) (
    input  logic  [NUM_CH-1:0][KEY_W-1:0] key,
    output rank_t [NUM_CH-1:0]            rankOfCh,
    output rank_t [NUM_CH-1:0]            chOfRank
);
    always_comb begin
        rankOfCh = '0;
        chOfRank = '0;
        // Rank = number of channels that beat this one; strict total order keeps it a bijection.
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (j != i && (key[j] > key[i] || (key[j] == key[i] && j < i)))
                    rankOfCh[i] = rankOfCh[i] + rank_t'(1);
            end
        end
        for (int r = 0; r < NUM_CH; r++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rankOfCh[i] == rank_t'(r)) chOfRank[r] = rank_t'(i);
            end
        end
    end
endmodule

// File: rtl/sw_alloc_sched.sv
// Rank-ordering scheduler and multicast-residue tracker around the 4-channel port allocator.
module sw_alloc_sched
    import sw_alloc_sched_pkg::*;
#(
    parameter int AGE_W        = 8,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input logic           clk,
    input logic           rst_n,
    sw_alloc_sched_if.slave io
);
    localparam int KEY_W = AGE_W + 2;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [NUM_CH-1:0]                holdValid, holdMc, starveQ;
    pv_t  [NUM_CH-1:0]                holdPpv;
    logic [NUM_CH-1:0][AGE_W-1:0]     holdAge;
    logic [NUM_CH-1:0][CNT_W-1:0]     waitCnt, waitNext;

    logic  [NUM_CH-1:0][KEY_W-1:0]    key;
    rank_t [NUM_CH-1:0]               rankOfCh, chOfRank;

    pv_t  [NUM_CH-1:0]                grant, sendPv, residue;
    logic [NUM_CH-1:0]                retire, loadEn, sendAny;

    // Empty channels get the lowest key so they sink to the bottom ranks.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) key[i] = {holdValid[i], starveQ[i], holdAge[i]};
    end

    sched_rank4 #(.KEY_W(KEY_W)) uRank (
        .key      (key),
        .rankOfCh (rankOfCh),
        .chOfRank (chOfRank)
    );

    always_comb begin
        io.al_mc  = '0;
        io.al_ppv = '0;
        for (int r = 0; r < NUM_CH; r++) begin
            io.al_mc[r]                       = holdValid[chOfRank[r]] & holdMc[chOfRank[r]];
            io.al_ppv[r*NUM_PORT +: NUM_PORT] = holdValid[chOfRank[r]] ? holdPpv[chOfRank[r]] : '0;
        end
    end

    assign io.al_numflit = popCount4(holdValid);

    always_comb begin
        grant   = '0;
        sendPv  = '0;
        residue = '0;
        retire  = '0;
        sendAny = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = holdValid[i] ? io.al_pv[rankOfCh[i]*NUM_PORT +: NUM_PORT] : '0;
            if (holdMc[i]) begin
                // Ports granted outside the remaining ppv carry no useful copy and are dropped.
                sendPv[i]  = grant[i] & holdPpv[i];
                residue[i] = holdPpv[i] & ~sendPv[i];
                retire[i]  = holdValid[i] && (residue[i] == '0);
            end else begin
                sendPv[i]  = grant[i];
                residue[i] = holdPpv[i];
                retire[i]  = (grant[i] != '0);
            end
            sendAny[i] = (sendPv[i] != '0);
        end
    end

    assign io.in_ready = ~holdValid | retire;
    assign loadEn      = io.in_valid & io.in_ready;
    assign io.starve   = starveQ;

    always_comb begin
        waitNext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (loadEn[i] || retire[i])   waitNext[i] = '0;
            else if (!holdValid[i])       waitNext[i] = '0;
            else if (waitCnt[i] == LIMIT) waitNext[i] = LIMIT;
            else                          waitNext[i] = waitCnt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdValid <= '0;
            holdMc    <= '0;
            holdPpv   <= '0;
            holdAge   <= '0;
            waitCnt   <= '0;
            starveQ   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (loadEn[i]) begin
                    holdValid[i] <= 1'b1;
                    // A zero ppv means deflect-only, which is handled as unicast.
                    holdMc[i]    <= io.in_mc[i] & (|io.in_ppv[i*NUM_PORT +: NUM_PORT]);
                    holdPpv[i]   <= io.in_ppv[i*NUM_PORT +: NUM_PORT];
                    holdAge[i]   <= io.in_age[i*AGE_W +: AGE_W];
                end else if (retire[i]) begin
                    holdValid[i] <= 1'b0;
                end else if (holdValid[i]) begin
                    holdPpv[i]   <= residue[i];
                end
                waitCnt[i] <= waitNext[i];
                starveQ[i] <= (waitNext[i] == LIMIT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= '0;
            io.out_pv    <= '0;
            io.out_last  <= '0;
        end else begin
            io.out_valid <= sendAny;
            io.out_pv    <= sendPv;
            io.out_last  <= retire & sendAny;
        end
    end

endmodule

// File: tb/tb_sw_alloc_sched.sv
// Directed-vector bench for sw_alloc_sched with hand-computed expectations.
module tb_sw_alloc_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sw_alloc_sched_if #(.AGE_W(8)) bus ();

    sw_alloc_sched #(.AGE_W(8), .STARVE_LIMIT(15), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int ch, input logic mc, input logic [3:0] ppv, input logic [7:0] age);
        bus.in_valid[ch]        = 1'b1;
        bus.in_mc[ch]           = mc;
        bus.in_ppv[ch*4 +: 4]   = ppv;
        bus.in_age[ch*8 +: 8]   = age;
    endtask

    task automatic idle();
        bus.in_valid = '0;
        bus.in_mc    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus.in_valid = '0;
        bus.in_mc    = '0;
        bus.in_ppv   = '0;
        bus.in_age   = '0;
        bus.al_pv    = '0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'hF);
        chk("rst_numflit",   32'(bus.al_numflit), 32'h0);
        chk("rst_starve",    32'(bus.starve),    32'h0);
        #10 rst_n = 1'b1;
        tick();

        // single unicast
        offer(0, 1'b0, 4'b0010, 8'd5);
        #1 chk("uc_in_ready", 32'(bus.in_ready), 32'hF);
        tick();
        idle();
        #1;
        chk("uc_al_mc",   32'(bus.al_mc),      32'h0);
        chk("uc_al_ppv",  32'(bus.al_ppv),     32'h0002);
        chk("uc_numflit", 32'(bus.al_numflit), 32'h1);
        bus.al_pv = 16'h0002;
        #1 chk("uc_ready_retire", 32'(bus.in_ready), 32'hF);
        tick();
        bus.al_pv = '0;
        chk("uc_out_valid", 32'(bus.out_valid), 32'h1);
        chk("uc_out_pv",    32'(bus.out_pv),    32'h0002);
        chk("uc_out_last",  32'(bus.out_last),  32'h1);
        chk("uc_drained",   32'(bus.al_numflit), 32'h0);

        // zero-ppv multicast degenerates to deflect-only unicast
        offer(1, 1'b1, 4'b0000, 8'd4);
        tick();
        idle();
        #1;
        chk("zp_al_mc",  32'(bus.al_mc),  32'h0);
        chk("zp_al_ppv", 32'(bus.al_ppv), 32'h0);
        bus.al_pv = 16'h0004;
        tick();
        bus.al_pv = '0;
        chk("zp_out_valid", 32'(bus.out_valid), 32'h2);
        chk("zp_out_pv",    32'(bus.out_pv),    32'h0040);
        chk("zp_out_last",  32'(bus.out_last),  32'h2);

        // age ranking: ch2 (age 9) ahead of ch1 (age 3)
        offer(2, 1'b0, 4'b0100, 8'd9);
        offer(1, 1'b0, 4'b1000, 8'd3);
        tick();
        idle();
        #1;
        chk("age_al_ppv",  32'(bus.al_ppv),     32'h0084);
        chk("age_numflit", 32'(bus.al_numflit), 32'h2);
        bus.al_pv = 16'h0084;
        tick();
        bus.al_pv = '0;
        chk("age_out_valid", 32'(bus.out_valid), 32'h6);
        chk("age_out_pv",    32'(bus.out_pv),    32'h0480);
        chk("age_out_last",  32'(bus.out_last),  32'h6);

        // equal ages: lower index wins
        offer(1, 1'b0, 4'b0001, 8'd7);
        offer(3, 1'b0, 4'b0010, 8'd7);
        tick();
        idle();
        #1 chk("tie_al_ppv", 32'(bus.al_ppv), 32'h0021);
        bus.al_pv = 16'h0021;
        tick();
        bus.al_pv = '0;
        chk("tie_out_pv", 32'(bus.out_pv), 32'h2010);

        // multicast split delivery with a dropped extra port
        offer(0, 1'b1, 4'b1011, 8'd2);
        tick();
        idle();
        #1;
        chk("mc_al_mc",  32'(bus.al_mc),  32'h1);
        chk("mc_al_ppv", 32'(bus.al_ppv), 32'h000B);
        bus.al_pv = 16'h0001;
        #1 chk("mc_ready_hold", 32'(bus.in_ready), 32'hE);
        tick();
        bus.al_pv = '0;
        #1;
        chk("mc1_out_valid", 32'(bus.out_valid), 32'h1);
        chk("mc1_out_pv",    32'(bus.out_pv),    32'h0001);
        chk("mc1_out_last",  32'(bus.out_last),  32'h0);
        chk("mc_residue",    32'(bus.al_ppv),    32'h000A);
        bus.al_pv = 16'h000E;
        #1 chk("mc_ready_done", 32'(bus.in_ready), 32'hF);
        tick();
        bus.al_pv = '0;
        chk("mc2_out_pv",   32'(bus.out_pv),   32'h000A);
        chk("mc2_out_last", 32'(bus.out_last), 32'h1);
        chk("mc2_numflit",  32'(bus.al_numflit), 32'h0);

        // starvation: ch3 age 0 is never granted for 15 cycles
        offer(3, 1'b0, 4'b0001, 8'd0);
        tick();
        idle();
        tick();
        tick();
        offer(0, 1'b0, 4'b0010, 8'd9);
        tick();
        idle();
        repeat (11) tick();
        chk("st_pre_starve", 32'(bus.starve), 32'h0);
        chk("st_pre_rank",   32'(bus.al_ppv), 32'h0012);
        tick();
        chk("st_starve",     32'(bus.starve), 32'h8);
        chk("st_rank",       32'(bus.al_ppv), 32'h0021);
        bus.al_pv = 16'h0001;
        #1 chk("st_ready", 32'(bus.in_ready), 32'hE);
        tick();
        bus.al_pv = '0;
        chk("st_cleared", 32'(bus.starve), 32'h0);
        chk("st_out_pv",  32'(bus.out_pv), 32'h1000);
        chk("st_left",    32'(bus.al_ppv), 32'h0002);
        bus.al_pv = 16'h0002;
        tick();
        bus.al_pv = '0;
        chk("st_flush", 32'(bus.out_pv), 32'h0002);

        // back-to-back retire and load on ch1
        offer(1, 1'b0, 4'b0001, 8'd4);
        tick();
        offer(1, 1'b0, 4'b0100, 8'd6);
        bus.al_pv = 16'h0001;
        #1 chk("b2b_ready", 32'(bus.in_ready), 32'hF);
        tick();
        idle();
        bus.al_pv = '0;
        #1;
        chk("b2b_out_pv",  32'(bus.out_pv),     32'h0010);
        chk("b2b_al_ppv",  32'(bus.al_ppv),     32'h0004);
        chk("b2b_numflit", 32'(bus.al_numflit), 32'h1);
        bus.al_pv = 16'h0004;
        tick();
        bus.al_pv = '0;
        chk("b2b_out_pv2", 32'(bus.out_pv), 32'h0040);

        // asynchronous reset with multicast residue pending
        offer(2, 1'b1, 4'b0111, 8'd3);
        tick();
        idle();
        bus.al_pv = 16'h0001;
        tick();
        bus.al_pv = '0;
        chk("rr_out_valid", 32'(bus.out_valid), 32'h4);
        chk("rr_residue",   32'(bus.al_ppv),    32'h0006);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_out_valid0", 32'(bus.out_valid),  32'h0);
        chk("rr_out_pv0",    32'(bus.out_pv),     32'h0);
        chk("rr_out_last0",  32'(bus.out_last),   32'h0);
        chk("rr_starve0",    32'(bus.starve),     32'h0);
        chk("rr_numflit0",   32'(bus.al_numflit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rr_in_ready", 32'(bus.in_ready),   32'hF);
        chk("rr_numflit",  32'(bus.al_numflit), 32'h0);
        chk("rr_quiet",    32'(bus.out_valid),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
